// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the integer register-file write port among NUM_REQ
// writeback sources; the winning write is registered and presented one cycle later.
module writeback_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      hold,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic                      reg_wren,
   output logic [ADDR_W-1:0]         write_address,
   output logic [DATA_W-1:0]         write_data,
   output logic                      pend_valid
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   rr_ptr_r;
   logic [PTR_W-1:0]   grant_idx_s;
   logic [PTR_W-1:0]   next_ptr_s;
   logic               found_s;
   logic               xfer_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [ADDR_W-1:0]  sel_addr_s;
   logic [DATA_W-1:0]  sel_data_s;

   // Scan requesters starting at rr_ptr and pick the first valid one
   always_comb begin
      logic [PTR_W:0]   sum_v;
      logic [PTR_W-1:0] idx_v;
      grant_idx_s = '0;
      found_s     = 1'b0;
      sum_v       = '0;
      idx_v       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum_v = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
         if (sum_v >= (PTR_W+1)'(NUM_REQ)) begin
            idx_v = PTR_W'(sum_v - (PTR_W+1)'(NUM_REQ));
         end else begin
            idx_v = PTR_W'(sum_v);
         end
         if (!found_s && req_valid[idx_v]) begin
            found_s     = 1'b1;
            grant_idx_s = idx_v;
         end else begin
            found_s     = found_s;
            grant_idx_s = grant_idx_s;
         end
      end
   end

   // One-hot grant, suppressed by hold and while reset is asserted
   always_comb begin
      xfer_s  = found_s & ~hold & reset_n;
      grant_s = '0;
      if (xfer_s) begin
         grant_s[grant_idx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
      req_ready = grant_s;
   end

   // Winning write's payload and the pointer value following it
   always_comb begin
      sel_addr_s = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
      sel_data_s = req_data[grant_idx_s*DATA_W +: DATA_W];
      if (grant_idx_s == PTR_W'(NUM_REQ-1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_idx_s + PTR_W'(1);
      end
   end

   // Output register and round-robin pointer; x0 writes occupy a slot but never enable the file
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_r      <= '0;
         reg_wren      <= 1'b0;
         pend_valid    <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
      end else if (xfer_s) begin
         rr_ptr_r      <= next_ptr_s;
         reg_wren      <= (sel_addr_s != {ADDR_W{1'b0}});
         pend_valid    <= 1'b1;
         write_address <= sel_addr_s;
         write_data    <= sel_data_s;
      end else begin
         reg_wren      <= 1'b0;
         pend_valid    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized scoreboard bench for writeback_arbiter with a queue-based reference model.
module tb_writeback_arbiter;
   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              hold = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_data = '0;
   logic              reg_wren;
   logic [AW-1:0]     write_address;
   logic [DW-1:0]     write_data;
   logic              pend_valid;

   writeback_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_n(reset_n), .hold(hold), .req_valid(req_valid),
      .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
      .reg_wren(reg_wren), .write_address(write_address), .write_data(write_data),
      .pend_valid(pend_valid));

   always #5 clk = ~clk;

   typedef struct {
      logic          pend;
      logic          wren;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          q[$];
   int            total = 0;
   int            bad = 0;
   int            model_ptr = 0;
   bit            mon_on = 1'b0;
   logic [AW-1:0] last_addr = '0;
   logic [DW-1:0] last_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: entered at posedge+1, returns at the next posedge+1.
   task automatic step(input logic [N-1:0] v, input logic h, input logic [N*AW-1:0] a,
                       input logic [N*DW-1:0] d, output int g);
      exp_t          e;
      logic [N-1:0]  exp_ready;
      req_valid = v; hold = h; req_addr = a; req_data = d;
      #3;
      g = -1;
      if (!h) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (model_ptr + k) % N;
            if (g < 0 && v[i]) g = i;
         end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      if (g >= 0) begin
         last_addr = a[g*AW +: AW];
         last_data = d[g*DW +: DW];
         e.pend = 1'b1;
         e.wren = (last_addr != 0);
         model_ptr = (g + 1) % N;
      end else begin
         e.pend = 1'b0;
         e.wren = 1'b0;
      end
      e.addr = last_addr;
      e.data = last_data;
      q.push_back(e);
      mon_on = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic mon_stop();
      #3;
      mon_on = 1'b0;
      chk("queue_drained", 64'(q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   // Monitor: compare each registered output cycle against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #2;
         if (mon_on) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL scoreboard_underflow: got output with no expectation at %0t", $time);
            end else begin
               e = q.pop_front();
               chk("pend_valid", 64'(pend_valid), 64'(e.pend));
               chk("reg_wren", 64'(reg_wren), 64'(e.wren));
               chk("write_address", 64'(write_address), 64'(e.addr));
               chk("write_data", 64'(write_data), 64'(e.data));
            end
         end
      end
   end

   initial begin
      int            g;
      logic [N*AW-1:0] a;
      logic [N*DW-1:0] d;
      logic [N-1:0]  pend;
      int            p1_left;

      // Reset state with all requesters valid
      req_valid = '1;
      #12;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_wren", 64'(reg_wren), 64'd0);
      chk("rst_pend", 64'(pend_valid), 64'd0);
      chk("rst_addr", 64'(write_address), 64'd0);
      chk("rst_data", 64'(write_data), 64'd0);
      req_valid = '0;
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;

      // Single requester 1, addr 5
      a = '0; d = '0;
      a[1*AW +: AW] = 5'd5; d[1*DW +: DW] = 32'hDEADBEEF;
      step(3'b010, 1'b0, a, d, g);
      // Pointer now 2: all valid grants 2, 0, 1
      for (int i = 0; i < N; i++) begin
         a[i*AW +: AW] = AW'(i + 10); d[i*DW +: DW] = 32'hA000_0000 + 32'(i);
      end
      step(3'b111, 1'b0, a, d, g);
      step(3'b011, 1'b0, a, d, g);
      step(3'b010, 1'b0, a, d, g);
      // x0 write from requester 0
      a = '0; d = '0; d[0 +: DW] = 32'h1234;
      step(3'b001, 1'b0, a, d, g);
      // Requester 2 held off for 4 cycles, then granted
      a[2*AW +: AW] = 5'd17; d[2*DW +: DW] = 32'hCAFE_F00D;
      for (int i = 0; i < 4; i++) step(3'b100, 1'b1, a, d, g);
      step(3'b100, 1'b0, a, d, g);
      step(3'b000, 1'b0, a, d, g);
      // Requester 0 always valid, requester 1 for two transfers
      p1_left = 2;
      for (int i = 0; i < 6; i++) begin
         a[0 +: AW] = AW'(i + 1); d[0 +: DW] = 32'(i);
         a[AW +: AW] = AW'(i + 20); d[DW +: DW] = 32'(i + 100);
         step({1'b0, (p1_left > 0), 1'b1}, 1'b0, a, d, g);
         if (g == 1) p1_left--;
      end

      // Randomized traffic: requesters hold payload stable until the model grants them
      pend = '0;
      a = '0; d = '0;
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               pend[i] = 1'b1;
               a[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 31));
               d[i*DW +: DW] = $urandom;
            end else if (!pend[i]) begin
               a[i*AW +: AW] = AW'($urandom_range(0, 31));
               d[i*DW +: DW] = $urandom;
            end
         end
         step(pend, ($urandom_range(0, 7) == 0), a, d, g);
         if (g >= 0) pend[g] = 1'b0;
      end
      mon_stop();

      // Reset asserted between a transfer edge and the following edge
      a = '0; d = '0;
      a[AW +: AW] = 5'd7; d[DW +: DW] = 32'h0BAD_0001;
      req_valid = 3'b010; req_addr = a; req_data = d; hold = 1'b0;
      @(posedge clk); #1;
      req_valid = '0;
      chk("pre_rst_wren", 64'(reg_wren), 64'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_wren", 64'(reg_wren), 64'd0);
      chk("midrst_pend", 64'(pend_valid), 64'd0);
      chk("midrst_addr", 64'(write_address), 64'd0);
      chk("midrst_data", 64'(write_data), 64'd0);
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      model_ptr = 0; last_addr = '0; last_data = '0;

      // All valid from reset: grants 0, 1, 2 then pointer wraps to 0
      for (int i = 0; i < N; i++) begin
         a[i*AW +: AW] = AW'(i + 1); d[i*DW +: DW] = 32'h5000 + 32'(i);
      end
      step(3'b111, 1'b0, a, d, g);
      step(3'b110, 1'b0, a, d, g);
      step(3'b100, 1'b0, a, d, g);
      step(3'b111, 1'b0, a, d, g);
      step(3'b000, 1'b0, a, d, g);
      mon_stop();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
